// File: rtl/err_stats_gen.sv
// -----------------------------------------------------------------------------
// err_stats_gen
//
// Window statistics for one receive rail (I or Q) at symbol rate. Over a
// window of 2^LOG2_WIN accepted symbols it produces:
//   - the mean of the input samples (DC estimate)
//   - the mean squared error against a built-in 4-level slicer (MSE)
// Optionally (ERR_PEAK_EN defined) it also produces the peak |err| over the
// window. With ERR_PEAK_EN undefined the err_peak_out port and its logic are
// absent.
//
// Parameters
//   DATA_W     width of signed samples, reference level and outputs
//   LOG2_WIN   log2 of the window length in accepted symbols
//   SYNC_MODE  0 = free-running windows, 1 = windows aligned to cycle_start
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   sym_en       in   symbol-rate enable; samples accepted only when high
//   cycle_start  in   window-alignment pulse (SYNC_MODE=1 only)
//   in_sig       in   signed input sample
//   ref_level    in   signed slicer reference b (levels +/-b, +/-3b), b >= 0
//   acc_dc_out   out  window mean of in_sig
//   acc_sq_out   out  window mean squared slicer error (never negative)
//   out_valid    out  one-cycle pulse when the outputs update
//   err_peak_out out  peak |err| over the window (ERR_PEAK_EN only)
// -----------------------------------------------------------------------------
module err_stats_gen #(
    parameter int DATA_W    = 18,
    parameter int LOG2_WIN  = 18,
    parameter int SYNC_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sym_en,
    input  logic                     cycle_start,
    input  logic signed [DATA_W-1:0] in_sig,
    input  logic signed [DATA_W-1:0] ref_level,
    output logic signed [DATA_W-1:0] acc_dc_out,
    output logic signed [DATA_W-1:0] acc_sq_out,
    output logic                     out_valid
`ifdef ERR_PEAK_EN
    ,
    output logic        [DATA_W-1:0] err_peak_out
`endif
);

    localparam int SW = DATA_W + 2;             // slicer arithmetic width
    localparam int EW = DATA_W + 3;             // error width, cannot wrap
    localparam int PW = 2 * EW;                 // full square width
    localparam int AW = DATA_W + LOG2_WIN + 1;  // accumulator width

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [PW-1:0]     SAT_P   = PW'(SAT_MAX);
    localparam logic [EW-1:0]     SAT_E   = EW'(SAT_MAX);
    localparam logic [AW-1:0]     SAT_A   = AW'(SAT_MAX);

    // ---------------------------------------------------------------- slicer
    logic signed [SW-1:0] in_x;
    logic signed [SW-1:0] b_x;
    logic signed [SW-1:0] thr;
    logic signed [SW-1:0] b3;
    logic signed [SW-1:0] decided;

    assign in_x = SW'(in_sig);
    assign b_x  = SW'(ref_level);
    assign thr  = b_x + b_x;
    assign b3   = thr + b_x;

    // Ties sit on the upper decision region.
    always_comb begin
        decided = -b3;
        if (in_x >= thr) begin
            decided = b3;
        end else if (!in_x[SW-1]) begin
            decided = b_x;
        end else if (in_x >= -thr) begin
            decided = -b_x;
        end
    end

    // ---------------------------------------------------------- error terms
    logic signed [EW-1:0]     err;
    logic signed [PW-1:0]     sq;
    logic        [PW-1:0]     sq_sh;
    logic        [DATA_W-1:0] term;
    logic        [EW-1:0]     err_abs;
    logic        [DATA_W-1:0] err_abs_sat;

    assign err   = EW'(in_x) - EW'(decided);
    assign sq    = PW'(err) * PW'(err);
    assign sq_sh = $unsigned(sq) >> (DATA_W - 1);
    assign term  = (sq_sh > SAT_P) ? SAT_MAX : DATA_W'(sq_sh);

    assign err_abs     = err[EW-1] ? $unsigned(-err) : $unsigned(err);
    assign err_abs_sat = (err_abs > SAT_E) ? SAT_MAX : DATA_W'(err_abs);

    // ------------------------------------------------------------ state
    logic signed [AW-1:0]       dc_acc_q, dc_acc_d;
    logic        [AW-1:0]       sq_acc_q, sq_acc_d;
    logic        [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic                       armed_q, armed_d;
    logic signed [DATA_W-1:0]   dc_out_q, dc_out_d;
    logic signed [DATA_W-1:0]   sq_out_q, sq_out_d;
    logic                       valid_q, valid_d;
`ifdef ERR_PEAK_EN
    logic        [DATA_W-1:0]   peak_q, peak_d;
    logic        [DATA_W-1:0]   peak_out_q, peak_out_d;
    logic        [DATA_W-1:0]   peak_new;
    assign peak_new = (err_abs_sat > peak_q) ? err_abs_sat : peak_q;
`endif

    // Window-close sums include the closing sample itself.
    logic signed [AW-1:0] dc_sum;
    logic        [AW-1:0] sq_sum;
    logic        [AW-1:0] sq_mean;

    assign dc_sum  = dc_acc_q + AW'(in_sig);
    assign sq_sum  = sq_acc_q + AW'(term);
    assign sq_mean = sq_sum >> LOG2_WIN;

    // A sync restart takes priority over everything, including a close on
    // the same edge: the partial window is dropped silently.
    logic restart;
    logic accept;
    logic close;

    assign restart = (SYNC_MODE != 0) && sym_en && cycle_start;
    assign accept  = sym_en && !restart && ((SYNC_MODE == 0) || armed_q);
    assign close   = accept && (&cnt_q);

    always_comb begin
        dc_acc_d = dc_acc_q;
        sq_acc_d = sq_acc_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        dc_out_d = dc_out_q;
        sq_out_d = sq_out_q;
        valid_d  = 1'b0;
`ifdef ERR_PEAK_EN
        peak_d     = peak_q;
        peak_out_d = peak_out_q;
`endif
        if (restart) begin
            dc_acc_d = AW'(in_sig);
            sq_acc_d = AW'(term);
            cnt_d    = LOG2_WIN'(1);
            armed_d  = 1'b1;
`ifdef ERR_PEAK_EN
            peak_d   = err_abs_sat;
`endif
        end else if (close) begin
            dc_out_d = DATA_W'(dc_sum >>> LOG2_WIN);
            sq_out_d = (sq_mean > SAT_A) ? SAT_MAX : DATA_W'(sq_mean);
            valid_d  = 1'b1;
            dc_acc_d = '0;
            sq_acc_d = '0;
            cnt_d    = '0;
`ifdef ERR_PEAK_EN
            peak_out_d = peak_new;
            peak_d     = '0;
`endif
        end else if (accept) begin
            dc_acc_d = dc_sum;
            sq_acc_d = sq_sum;
            cnt_d    = cnt_q + LOG2_WIN'(1);
`ifdef ERR_PEAK_EN
            peak_d   = peak_new;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dc_acc_q <= '0;
            sq_acc_q <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            dc_out_q <= '0;
            sq_out_q <= '0;
            valid_q  <= 1'b0;
`ifdef ERR_PEAK_EN
            peak_q     <= '0;
            peak_out_q <= '0;
`endif
        end else begin
            dc_acc_q <= dc_acc_d;
            sq_acc_q <= sq_acc_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            dc_out_q <= dc_out_d;
            sq_out_q <= sq_out_d;
            valid_q  <= valid_d;
`ifdef ERR_PEAK_EN
            peak_q     <= peak_d;
            peak_out_q <= peak_out_d;
`endif
        end
    end

    assign acc_dc_out = dc_out_q;
    assign acc_sq_out = sq_out_q;
    assign out_valid  = valid_q;
`ifdef ERR_PEAK_EN
    assign err_peak_out = peak_out_q;
`endif

endmodule

// File: tb/tb_err_stats_gen.sv
// -----------------------------------------------------------------------------
// tb_err_stats_gen
//
// Drives a free-running instance and a cycle_start-synced instance with the
// same stimulus (16-symbol windows, sym_en every 4 clocks). A window-level
// model predicts each instance's outputs every cycle; literal expectations
// pin selected windows.
// -----------------------------------------------------------------------------
module tb_err_stats_gen;

    localparam int DW  = 18;
    localparam int LW  = 4;
    localparam int WIN = 1 << LW;
    localparam longint MAXV = (64'sd1 << (DW - 1)) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 sym_en = 1'b0;
    logic                 cycle_start = 1'b0;
    logic signed [DW-1:0] in_sig = '0;
    logic signed [DW-1:0] ref_level = '0;

    logic signed [DW-1:0] dc_o [2];
    logic signed [DW-1:0] sq_o [2];
    logic                 vld_o [2];
`ifdef ERR_PEAK_EN
    logic        [DW-1:0] pk_o [2];
`endif

    always #5 clk = ~clk;

    err_stats_gen #(.DATA_W(DW), .LOG2_WIN(LW), .SYNC_MODE(0)) u_free (
        .clk         (clk),
        .reset       (reset),
        .sym_en      (sym_en),
        .cycle_start (cycle_start),
        .in_sig      (in_sig),
        .ref_level   (ref_level),
        .acc_dc_out  (dc_o[0]),
        .acc_sq_out  (sq_o[0]),
        .out_valid   (vld_o[0])
`ifdef ERR_PEAK_EN
        ,
        .err_peak_out(pk_o[0])
`endif
    );

    err_stats_gen #(.DATA_W(DW), .LOG2_WIN(LW), .SYNC_MODE(1)) u_sync (
        .clk         (clk),
        .reset       (reset),
        .sym_en      (sym_en),
        .cycle_start (cycle_start),
        .in_sig      (in_sig),
        .ref_level   (ref_level),
        .acc_dc_out  (dc_o[1]),
        .acc_sq_out  (sq_o[1]),
        .out_valid   (vld_o[1])
`ifdef ERR_PEAK_EN
        ,
        .err_peak_out(pk_o[1])
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    function automatic longint slice_of(input longint v, input longint b);
        if (v >= 2 * b)       return 3 * b;
        else if (v >= 0)      return b;
        else if (v >= -2 * b) return -b;
        else                  return -3 * b;
    endfunction

    // Window contents summarised as plain sums over the accepted symbols.
    int     m_n    [2];
    longint m_sin  [2];
    longint m_st   [2];
    longint m_pkr  [2];
    bit     m_arm  [2];
    longint m_dc   [2];
    longint m_sq   [2];
    longint m_pk   [2];
    bit     m_vld  [2];

    always @(posedge clk) begin
        longint v, b, e, t, a;
        v = in_sig;
        b = ref_level;
        e = v - slice_of(v, b);
        t = (e * e) / (64'sd1 << (DW - 1));
        if (t > MAXV) t = MAXV;
        a = (e < 0) ? -e : e;
        if (a > MAXV) a = MAXV;
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 1'b0;
            if (reset) begin
                m_n[k] = 0; m_sin[k] = 0; m_st[k] = 0; m_pkr[k] = 0; m_arm[k] = 1'b0;
                m_dc[k] = 0; m_sq[k] = 0; m_pk[k] = 0;
            end else if (sym_en) begin
                if (k == 1 && cycle_start) begin
                    m_arm[k] = 1'b1;
                    m_n[k] = 1; m_sin[k] = v; m_st[k] = t; m_pkr[k] = a;
                end else if (k == 0 || m_arm[k]) begin
                    m_n[k]++;
                    m_sin[k] += v;
                    m_st[k]  += t;
                    if (a > m_pkr[k]) m_pkr[k] = a;
                    if (m_n[k] == WIN) begin
                        m_dc[k]  = m_sin[k] >>> LW;
                        m_sq[k]  = m_st[k] / WIN;
                        if (m_sq[k] > MAXV) m_sq[k] = MAXV;
                        m_pk[k]  = m_pkr[k];
                        m_vld[k] = 1'b1;
                        m_n[k] = 0; m_sin[k] = 0; m_st[k] = 0; m_pkr[k] = 0;
                    end
                end
            end
        end
    end

    // -------------------------------------------------- per-cycle compare
    int     nv      [2] = '{0, 0};
    longint last_dc [2] = '{0, 0};
    longint last_sq [2] = '{0, 0};
    longint last_pk [2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("inst%0d out_valid", k), longint'(vld_o[k]), longint'(m_vld[k]));
            chk($sformatf("inst%0d acc_dc_out", k), longint'(dc_o[k]), m_dc[k]);
            chk($sformatf("inst%0d acc_sq_out", k), longint'(sq_o[k]), m_sq[k]);
`ifdef ERR_PEAK_EN
            chk($sformatf("inst%0d err_peak_out", k), longint'(pk_o[k]), m_pk[k]);
            if (vld_o[k]) last_pk[k] = longint'(pk_o[k]);
`endif
            if (vld_o[k]) begin
                nv[k]++;
                last_dc[k] = longint'(dc_o[k]);
                last_sq[k] = longint'(sq_o[k]);
                $display("[TB] inst%0d window: dc=%0d sq=%0d", k, dc_o[k], sq_o[k]);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    int base0, base1;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sym_en = 1'b0; cycle_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base0 = nv[0];
        base1 = nv[1];
    endtask

    task automatic send_sym(input longint v, input bit cs);
        @(negedge clk);
        in_sig = DW'(v); cycle_start = cs; sym_en = 1'b1;
        @(negedge clk);
        sym_en = 1'b0; cycle_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_n(input int n, input longint v);
        for (int i = 0; i < n; i++) send_sym(v, 1'b0);
    endtask

    initial begin
        // T1 and reset state
        ref_level = 18'sd16384;
        do_reset();
        chk("reset dc", longint'(dc_o[0]), 0);
        chk("reset sq", longint'(sq_o[0]), 0);
        chk("reset valid", longint'(vld_o[0]), 0);
        send_n(15, 17384);
        chk("T1 no early valid", nv[0] - base0, 0);
        send_sym(17384, 1'b0);
        chk("T1 valid count", nv[0] - base0, 1);
        chk("T1 dc", last_dc[0], 17384);
        chk("T1 sq", last_sq[0], 7);
        repeat (8) @(negedge clk);
        chk("T1 hold dc", longint'(dc_o[0]), 17384);

        // T2: exact -3b, then tie at thr
        do_reset();
        send_n(16, -49152);
        chk("T2a dc", last_dc[0], -49152);
        chk("T2a sq", last_sq[0], 0);
        send_n(16, 32768);
        chk("T2b dc", last_dc[0], 32768);
        chk("T2b sq", last_sq[0], 2048);
        chk("T2 valid count", nv[0] - base0, 2);

        // T3: full-scale negative input; b=0 drives term and mean to saturation
        do_reset();
        ref_level = 18'sd131071;
        send_n(16, -131072);
        chk("T3a dc", last_dc[0], -131072);
        chk("T3a sq", last_sq[0], 0);
        ref_level = 18'sd0;
        send_n(16, -131072);
        chk("T3b dc", last_dc[0], -131072);
        chk("T3b sq", last_sq[0], 131071);
`ifdef ERR_PEAK_EN
        chk("T3b peak", last_pk[0], 131071);
`endif

        // T4: sync-mode alignment
        ref_level = 18'sd16384;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send_sym((i * 7919) % 200000 - 100000, 1'b0);
            if (i == 20) begin
                @(negedge clk); cycle_start = 1'b1;
                @(negedge clk); cycle_start = 1'b0;
            end
        end
        chk("T4 unarmed no valid", nv[1] - base1, 0);
        send_sym(30000, 1'b1);
        send_n(4, 30000);
        send_sym(-20000, 1'b1);
        send_n(14, -20000);
        chk("T4 no valid before sym20", nv[1] - base1, 0);
        send_sym(-20000, 1'b0);
        chk("T4 valid after sym20", nv[1] - base1, 1);
        chk("T4 dc", last_dc[1], -20000);
        chk("T4 sq", last_sq[1], 99);
        send_n(15, 5000);
        send_sym(-20000, 1'b1);
        chk("T4 terminal restart no valid", nv[1] - base1, 1);
        send_n(15, -20000);
        chk("T4 valid after restart", nv[1] - base1, 2);
        chk("T4 restart dc", last_dc[1], -20000);

        // T5: reset mid-window
        do_reset();
        send_n(16, 17384);
        send_n(9, -5000);
        do_reset();
        chk("T5 dc cleared", longint'(dc_o[0]), 0);
        chk("T5 sq cleared", longint'(sq_o[0]), 0);
        send_n(15, 17384);
        chk("T5 no early valid", nv[0] - base0, 0);
        chk("T5 dc still 0", longint'(dc_o[0]), 0);
        send_sym(17384, 1'b0);
        chk("T5 valid once", nv[0] - base0, 1);
        chk("T5 dc", last_dc[0], 17384);

        // T6: error peak window then clean window
        do_reset();
        send_n(3, 16384);
        send_sym(16484, 1'b0);
        send_n(4, 16384);
        send_sym(15484, 1'b0);
        send_sym(16684, 1'b0);
        send_n(6, 16384);
        chk("T6a dc", last_dc[0], 16352);
        chk("T6a sq", last_sq[0], 0);
`ifdef ERR_PEAK_EN
        chk("T6a peak", last_pk[0], 900);
`endif
        send_n(16, 16384);
        chk("T6b dc", last_dc[0], 16384);
`ifdef ERR_PEAK_EN
        chk("T6b peak", last_pk[0], 0);
`endif
        chk("T6 valid count", nv[0] - base0, 2);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
